golden_nonce_fifo: RTL

- Sits directly downstream of the miner core's golden_nonce output and upstream of the host output shift register.
- Detects each new golden nonce reported by the core and queues it in a small FIFO, so the host never loses nonces found between two reads.
- The host read logic pops one entry per completed readout.
- Replaces the two-deep golden_nonce1/golden_nonce2 history with a deeper, overflow-flagged queue.

---
 rtl/btcminer_pkg.sv | 18 +
 rtl/gn_fifo_mem.sv | 27 ++
 rtl/golden_nonce_fifo.sv | 117 +++++++++++
 3 files changed

// File: rtl/btcminer_pkg.sv
// Shared miner constants: nonce width, golden-nonce FIFO default depth and
// the host readout word layout used by both this FIFO and the output shifter.
package btcminer_pkg;

    localparam int NONCE_W               = 32;
    localparam int GN_FIFO_DEPTH_DEFAULT = 8;

    // Host word: [31:0] nonce, [32] valid, [33] overflow
    localparam int HOST_NONCE_LSB = 0;
    localparam int HOST_VALID_BIT = NONCE_W;
    localparam int HOST_OVF_BIT   = NONCE_W + 1;
    localparam int HOST_WORD_W    = NONCE_W + 2;

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/gn_fifo_mem.sv
// Golden-nonce storage: DEPTH x NONCE_W register array with one synchronous
// write port and one asynchronous read port. Storage is not reset.
module gn_fifo_mem
    import btcminer_pkg::*;
#(
    parameter int DEPTH = GN_FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [NONCE_W-1:0] wr_data_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [NONCE_W-1:0] rd_data_o
);

    logic [NONCE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/golden_nonce_fifo.sv
// Queues each new golden nonce from the miner core for the host readout logic.
// Build option GOLDEN_NONCE_FIFO_OVERWRITE_EN: on full, drop oldest instead of newest.
module golden_nonce_fifo
    import btcminer_pkg::*;
#(
    parameter  int DEPTH = GN_FIFO_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NONCE_W-1:0] golden_nonce,
    input  logic               clear,
    input  logic               pop,
    output logic [NONCE_W-1:0] out_nonce,
    output logic               out_valid,
    output logic [AW:0]        count,
    output logic               overflow
);

    if (!is_pow2(DEPTH) || DEPTH > 256) begin : g_bad_depth
        $error("golden_nonce_fifo: DEPTH must be a power of two in 2..256");
    end

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [NONCE_W-1:0] gn_in_q, gn_last_q, gn_last_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               new_nonce, empty, full, push, pop_ok, wr_en;
    logic [NONCE_W-1:0] rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gn_in_q    <= '0;
            gn_last_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            gn_in_q    <= golden_nonce;
            gn_last_q  <= gn_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        new_nonce  = (gn_in_q != gn_last_q);
        empty      = (count_q == '0);
        full       = (count_q == FULL_CNT);
        push       = new_nonce && !clear;
        pop_ok     = pop && !empty && !clear;

        // gn_last tracks every detected change, even when cleared or dropped,
        // so a held core value is never queued twice.
        gn_last_d  = new_nonce ? gn_in_q : gn_last_q;
        wr_en      = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                if (!full || pop_ok) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end else begin
                    overflow_d = 1'b1;
`ifdef GOLDEN_NONCE_FIFO_OVERWRITE_EN
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
`endif
                end
            end
            // An overwrite on full moves both pointers but keeps count at DEPTH.
            if (wr_en && !pop_ok && !full) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (!wr_en && pop_ok) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end
    end

    gn_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (gn_in_q),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    always_comb begin
        out_valid = !empty;
        out_nonce = empty ? '0 : rd_data;
        count     = count_q;
        overflow  = overflow_q;
    end

endmodule
